ff_input_cond: RTL and testbench

//  Player-input conditioner for Food Fight: synchronises and debounces raw board buttons, and shapes coin inputs.

---
 rtl/ff_input_pkg.sv | 27 ++
 rtl/ff_debounce.sv | 52 +++++
 rtl/ff_input_cond.sv | 179 +++++++++++++++++
 tb/tb_ff_input_cond.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_input_pkg.sv
// Shared definitions for the Food Fight input conditioner: switch bit positions,
// coin channel FSM encoding and the all-released switch word.
package ff_input_pkg;

    localparam int SW_COIN1   = 7;
    localparam int SW_COIN2   = 6;
    localparam int SW_START1  = 5;
    localparam int SW_START2  = 4;
    localparam int SW_COINAUX = 3;
    localparam int SW_THROW1  = 2;
    localparam int SW_THROW2  = 1;
    localparam int SW_TEST    = 0;

    localparam logic [9:0] SW_IDLE = 10'h3FF;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ff_debounce.sv
// One-bit button conditioner: 2-flop synchroniser followed by a stability counter
// that accepts a new level only after CYCLES consecutive differing samples.
module ff_debounce
    import ff_input_pkg::*;
#(
    parameter int unsigned CYCLES = 120000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned         CNT_W    = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/ff_input_cond.sv
// Food Fight player-input conditioner: debounced level buttons, shaped coin pulses,
// coin counter and activity LED. Define FF_AUTOFIRE_EN to build throw-button autofire.
module ff_input_cond
    import ff_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 120000,
    parameter int unsigned COIN_PULSE_CYCLES = 600000,
    parameter int unsigned COIN_GAP_CYCLES   = 600000,
    parameter int unsigned AUTOFIRE_HALF     = 600000
) (
    input  logic       clk12m,
    input  logic       reset_n,
    input  logic [7:0] btn_i,
    input  logic       autofire_i,
    output logic [9:0] sw_o,
    output logic [7:0] coin_count_o,
    output logic       activity_o
);

    localparam int unsigned TMR_SPAN = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                       COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int unsigned      TMR_W     = cnt_width(TMR_SPAN);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(COIN_GAP_CYCLES - 1);

    logic [7:0]       stable;
    logic [2:0]       coin_stable;
    logic [2:0]       coin_rise;
    logic [2:0]       coin_prev_q;
    logic [2:0]       coin_enter;
    logic [2:0]       coin_low_d;
    logic [1:0]       n_start;
    coin_state_t      state_q [3];
    logic [TMR_W-1:0] tmr_q   [3];
    logic [7:0]       coin_cnt_q;
    logic [9:0]       sw_d;
    logic [9:0]       sw_q;
    logic             act_d;
    logic             act_q;

    for (genvar i = 0; i < 8; i++) begin : g_db
        ff_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i    (clk12m),
            .rst_ni   (reset_n),
            .raw_i    (btn_i[i]),
            .stable_o (stable[i])
        );
    end

    // Coin channel k: 0 = coin1, 1 = coin2, 2 = coinaux.
    assign coin_stable = {stable[SW_COINAUX], stable[SW_COIN2], stable[SW_COIN1]};
    assign coin_rise   = coin_stable & ~coin_prev_q;

    always_comb begin
        coin_enter = '0;
        coin_low_d = '0;
        for (int k = 0; k < 3; k++) begin
            coin_enter[k] = (state_q[k] == COIN_IDLE) && coin_rise[k];
            coin_low_d[k] = ((state_q[k] == COIN_IDLE) && coin_rise[k]) ||
                            ((state_q[k] == COIN_PULSE) && (tmr_q[k] != '0));
        end
    end

    assign n_start = {1'b0, coin_enter[0]} + {1'b0, coin_enter[1]} + {1'b0, coin_enter[2]};

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= COIN_IDLE;
                tmr_q[k]   <= '0;
            end
            coin_prev_q <= '0;
            coin_cnt_q  <= '0;
        end else begin
            coin_prev_q <= coin_stable;
            coin_cnt_q  <= coin_cnt_q + {6'd0, n_start};
            for (int k = 0; k < 3; k++) begin
                case (state_q[k])
                    COIN_IDLE: begin
                        if (coin_enter[k]) begin
                            state_q[k] <= COIN_PULSE;
                            tmr_q[k]   <= PULSE_LD;
                        end
                    end
                    COIN_PULSE: begin
                        if (tmr_q[k] == '0) begin
                            state_q[k] <= COIN_GAP;
                            tmr_q[k]   <= GAP_LD;
                        end else begin
                            tmr_q[k] <= tmr_q[k] - 1'b1;
                        end
                    end
                    COIN_GAP: begin
                        // A coin still held at the end of the gap keeps the channel parked here.
                        if (tmr_q[k] != '0) begin
                            tmr_q[k] <= tmr_q[k] - 1'b1;
                        end else if (!coin_stable[k]) begin
                            state_q[k] <= COIN_IDLE;
                        end
                    end
                    default: begin
                        state_q[k] <= COIN_IDLE;
                        tmr_q[k]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef FF_AUTOFIRE_EN
    localparam int unsigned     AF_W    = cnt_width(AUTOFIRE_HALF);
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_HALF - 1);

    logic            throw_held;
    logic [AF_W-1:0] af_cnt_q;
    logic [AF_W-1:0] af_cnt_d;
    logic            af_hi_q;
    logic            af_hi_d;

    assign throw_held = stable[SW_THROW1] | stable[SW_THROW2];

    always_comb begin
        af_cnt_d = af_cnt_q;
        af_hi_d  = af_hi_q;
        if (!throw_held) begin
            af_cnt_d = '0;
            af_hi_d  = 1'b0;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_d = '0;
            af_hi_d  = ~af_hi_q;
        end else begin
            af_cnt_d = af_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q <= '0;
            af_hi_q  <= 1'b0;
        end else begin
            af_cnt_q <= af_cnt_d;
            af_hi_q  <= af_hi_d;
        end
    end
`else
    logic unused_af;
    assign unused_af = autofire_i ^ (AUTOFIRE_HALF == 0);
`endif

    always_comb begin
        sw_d            = SW_IDLE;
        sw_d[7:0]       = ~stable;
        sw_d[SW_COIN1]  = ~coin_low_d[0];
        sw_d[SW_COIN2]  = ~coin_low_d[1];
        sw_d[SW_COINAUX] = ~coin_low_d[2];
`ifdef FF_AUTOFIRE_EN
        sw_d[SW_THROW1] = sw_d[SW_THROW1] | (autofire_i & af_hi_q);
        sw_d[SW_THROW2] = sw_d[SW_THROW2] | (autofire_i & af_hi_q);
`endif
        act_d = ~&sw_d[7:0];
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            sw_q  <= SW_IDLE;
            act_q <= 1'b0;
        end else begin
            sw_q  <= sw_d;
            act_q <= act_d;
        end
    end

    assign sw_o         = sw_q;
    assign activity_o   = act_q;
    assign coin_count_o = coin_cnt_q;

endmodule

// File: tb/tb_ff_input_cond.sv
// Randomized self-checking bench for ff_input_cond with shortened timing parameters;
// expected outputs come from a tick-indexed behavioural model of press/pulse timing.
module tb_ff_input_cond;
    import ff_input_pkg::*;

    localparam int D   = 4;
    localparam int P   = 8;
    localparam int G   = 6;
    localparam int H   = 5;
    localparam int LAT = D + 3;  // ticks from the first sampling edge to the output change

    logic       clk12m = 1'b0;
    logic       reset_n;
    logic [7:0] btn_i;
    logic       autofire_i;
    logic [9:0] sw_o;
    logic [7:0] coin_count_o;
    logic       activity_o;

    int vecs      = 0;
    int errs      = 0;
    int exp_count = 0;

    always #5 clk12m = ~clk12m;

    ff_input_cond #(
        .DEBOUNCE_CYCLES   (D),
        .COIN_PULSE_CYCLES (P),
        .COIN_GAP_CYCLES   (G),
        .AUTOFIRE_HALF     (H)
    ) dut (
        .clk12m       (clk12m),
        .reset_n      (reset_n),
        .btn_i        (btn_i),
        .autofire_i   (autofire_i),
        .sw_o         (sw_o),
        .coin_count_o (coin_count_o),
        .activity_o   (activity_o)
    );

    task automatic tick();
        @(posedge clk12m);
        @(negedge clk12m);
    endtask

    // Level channel held for p samples: low for p ticks starting at tick LAT, if accepted.
    function automatic bit level_low(input int n, input int p);
        return (p >= D) && (n >= LAT) && (n <= p + LAT - 1);
    endfunction

    // Coin pulse: fixed P ticks starting at tick LAT regardless of hold length.
    function automatic bit coin_low(input int n);
        return (n >= LAT) && (n < LAT + P);
    endfunction

    task automatic test_reset();
        btn_i      = 8'hFF;
        autofire_i = 1'b0;
        reset_n    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        vecs++; if (sw_o !== SW_IDLE) begin errs++; $display("FAIL rst_sw got %h want %h", sw_o, SW_IDLE); end
        vecs++; if (coin_count_o !== 8'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", coin_count_o); end
        vecs++; if (activity_o !== 1'b0) begin errs++; $display("FAIL rst_act got %b want 0", activity_o); end
        tick(); tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            tick();
            vecs++; if (sw_o !== SW_IDLE) begin errs++; $display("FAIL rst_hold_sw n=%0d got %h want %h", n, sw_o, SW_IDLE); end
            vecs++; if (coin_count_o !== 8'd0) begin errs++; $display("FAIL rst_hold_cnt n=%0d got %0d want 0", n, coin_count_o); end
            vecs++; if (activity_o !== 1'b0) begin errs++; $display("FAIL rst_hold_act n=%0d got %b want 0", n, activity_o); end
        end
        btn_i   = 8'h00;
        reset_n = 1'b0;
        tick(); tick();
        reset_n   = 1'b1;
        exp_count = 0;
        tick(); tick();
    endtask

    task automatic test_debounce();
        int         lv [5];
        int         b;
        int         p;
        logic [9:0] want;
        lv = '{SW_START1, SW_START2, SW_THROW1, SW_THROW2, SW_TEST};
        for (int it = 0; it < 10; it++) begin
            if (it == 0)      begin b = SW_START1; p = D - 1; end
            else if (it == 1) begin b = SW_START1; p = 12; end
            else begin
                b = lv[$urandom_range(0, 4)];
                p = (it < 5) ? int'($urandom_range(1, D - 1)) : int'($urandom_range(D, 10));
            end
            btn_i    = 8'h00;
            btn_i[b] = 1'b1;
            for (int n = 1; n <= p + LAT + 2; n++) begin
                tick();
                if (n == p) btn_i[b] = 1'b0;
                want = SW_IDLE;
                if (level_low(n, p)) want[b] = 1'b0;
                vecs++; if (sw_o !== want) begin errs++; $display("FAIL deb_sw bit=%0d p=%0d n=%0d got %h want %h", b, p, n, sw_o, want); end
                vecs++; if (activity_o !== level_low(n, p)) begin errs++; $display("FAIL deb_act bit=%0d p=%0d n=%0d got %b want %b", b, p, n, activity_o, level_low(n, p)); end
            end
            tick(); tick();
        end
    endtask

    task automatic test_coin_hold();
        int         p;
        logic [9:0] want;
        for (int r = 0; r < 2; r++) begin
            p = (r == 0) ? 100 : int'($urandom_range(D, 30));
            btn_i    = 8'h00;
            btn_i[SW_COIN1] = 1'b1;
            for (int n = 1; n <= p + LAT + P + G + 5; n++) begin
                tick();
                if (n == p) btn_i[SW_COIN1] = 1'b0;
                if (n == LAT) exp_count = (exp_count + 1) % 256;
                want = SW_IDLE;
                want[SW_COIN1] = ~coin_low(n);
                vecs++; if (sw_o !== want) begin errs++; $display("FAIL coin_sw r=%0d n=%0d got %h want %h", r, n, sw_o, want); end
                vecs++; if (coin_count_o !== 8'(exp_count)) begin errs++; $display("FAIL coin_cnt r=%0d n=%0d got %0d want %0d", r, n, coin_count_o, exp_count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] want;
        btn_i = 8'h00;
        btn_i[SW_COINAUX] = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n == 5)  btn_i[SW_COINAUX] = 1'b0;
            if (n == 10) btn_i[SW_COINAUX] = 1'b1;
            if (n == 40) btn_i[SW_COINAUX] = 1'b0;
            if (n == LAT) exp_count = (exp_count + 1) % 256;
            want = SW_IDLE;
            want[SW_COINAUX] = ~coin_low(n);
            vecs++; if (sw_o !== want) begin errs++; $display("FAIL b2b_sw n=%0d got %h want %h", n, sw_o, want); end
            vecs++; if (coin_count_o !== 8'(exp_count)) begin errs++; $display("FAIL b2b_cnt n=%0d got %0d want %0d", n, coin_count_o, exp_count); end
        end
    endtask

    task automatic test_coin_wrap();
        logic [7:0] mask;
        logic [9:0] want;
        int         add;
        for (int r = 0; r < 100 && exp_count != 255; r++) begin
            if (255 - exp_count >= 3)      begin mask = 8'hC8; add = 3; end
            else if (255 - exp_count == 2) begin mask = 8'hC0; add = 2; end
            else                           begin mask = 8'h80; add = 1; end
            btn_i = mask;
            for (int n = 1; n <= 35; n++) begin
                tick();
                if (n == 5) btn_i = 8'h00;
                if (n == LAT) begin
                    exp_count = (exp_count + add) % 256;
                    want = {2'b11, ~mask};
                    vecs++; if (sw_o !== want) begin errs++; $display("FAIL pre_sw r=%0d got %h want %h", r, sw_o, want); end
                end
            end
            vecs++; if (coin_count_o !== 8'(exp_count)) begin errs++; $display("FAIL pre_cnt r=%0d got %0d want %0d", r, coin_count_o, exp_count); end
        end
        btn_i = 8'hC0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 20) btn_i = 8'h00;
            if (n == LAT) exp_count = (exp_count + 2) % 256;
            want = SW_IDLE;
            want[SW_COIN1] = ~coin_low(n);
            want[SW_COIN2] = ~coin_low(n);
            vecs++; if (sw_o !== want) begin errs++; $display("FAIL wrap_sw n=%0d got %h want %h", n, sw_o, want); end
            vecs++; if (coin_count_o !== 8'(exp_count)) begin errs++; $display("FAIL wrap_cnt n=%0d got %0d want %0d", n, coin_count_o, exp_count); end
        end
    endtask

    task automatic test_midpulse_reset();
        logic [9:0] want;
        btn_i = 8'h00;
        btn_i[SW_COIN1] = 1'b1;
        for (int n = 1; n <= LAT + 2; n++) tick();
        want = SW_IDLE;
        want[SW_COIN1] = 1'b0;
        vecs++; if (sw_o !== want) begin errs++; $display("FAIL mid_pre_sw got %h want %h", sw_o, want); end
        reset_n = 1'b0;
        #1;
        exp_count = 0;
        vecs++; if (sw_o !== SW_IDLE) begin errs++; $display("FAIL mid_rst_sw got %h want %h", sw_o, SW_IDLE); end
        vecs++; if (coin_count_o !== 8'd0) begin errs++; $display("FAIL mid_rst_cnt got %0d want 0", coin_count_o); end
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == LAT) exp_count = 1;
            want = SW_IDLE;
            want[SW_COIN1] = ~coin_low(n);
            vecs++; if (sw_o !== want) begin errs++; $display("FAIL mid_post_sw n=%0d got %h want %h", n, sw_o, want); end
            vecs++; if (coin_count_o !== 8'(exp_count)) begin errs++; $display("FAIL mid_post_cnt n=%0d got %0d want %0d", n, coin_count_o, exp_count); end
        end
        btn_i = 8'h00;
        for (int n = 1; n <= 30; n++) tick();
    endtask

    task automatic test_autofire();
        int         b;
        bit         low;
        logic [9:0] want;
        b = ($urandom_range(0, 1) == 0) ? SW_THROW1 : SW_THROW2;
        autofire_i = 1'b1;
        btn_i      = 8'h00;
        btn_i[b]   = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (n == 40) autofire_i = 1'b0;
`ifdef FF_AUTOFIRE_EN
            low = (n >= LAT) && ((n > 40) || (((n - LAT) / H) % 2 == 0));
`else
            low = (n >= LAT);
`endif
            want = SW_IDLE;
            want[b] = ~low;
            vecs++; if (sw_o !== want) begin errs++; $display("FAIL af_sw bit=%0d n=%0d got %h want %h", b, n, sw_o, want); end
        end
        btn_i = 8'h00;
        for (int n = 1; n <= LAT + 3; n++) tick();
        vecs++; if (sw_o !== SW_IDLE) begin errs++; $display("FAIL af_rel_sw got %h want %h", sw_o, SW_IDLE); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_coin_hold();
        test_back_to_back();
        test_coin_wrap();
        test_midpulse_reset();
        test_autofire();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
